fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  RV32I instruction fetch stage: owns the PC, issues word requests to instruction memory,
//  buffers returned words with their PC in a small queue, and presents Instr/instr_pc to the
//  downstream decode field splitter via valid/ready. Taken branches/jumps redirect the PC
//  and squash everything older.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of first fetch after reset
//  DEPTH     2              queue entries; also max (queued + in-flight) words, >=1
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  redirect_valid  in   1   taken branch/jump this cycle
//  redirect_pc     in   32  new fetch target
//  imem_req_valid  out  1   request to instruction memory
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address (bits[1:0]=00)
//  imem_rsp_valid  in   1   read data returned, in request order, always accepted
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   Instr/instr_pc valid to decode
//  instr_ready     in   1   decode consumes
//  Instr           out  32  instruction word
//  instr_pc        out  32  PC of Instr
//  misalign_err    out  1   only with FETCH_MISALIGN_EN
// BEHAVIOUR
//  - Reset: pc=RESET_PC, queue empty, inflight=0, drop=0, state=IDLE; all outputs 0.
//  - FSM: IDLE -> FETCH unconditionally after one cycle (no request in IDLE). FETCH issues.
//    HALT exists only with FETCH_MISALIGN_EN.
//  - imem_req_valid = (state==FETCH) && (count + inflight < DEPTH) && !redirect_valid.
//  - Request handshake (valid&&ready): pc <= pc+4 (wraps mod 2^32), inflight++.
//  - Response: inflight--; if drop>0 then drop-- and word discarded, else push {pc_tag,data}.
//    pc_tag from an internal in-order PC-tag counter advanced on each kept push.
//  - Credit rule guarantees push never hits a full queue; overflow is a design error (assert).
//  - Output: instr_valid = !empty; pop on instr_valid&&instr_ready; min latency req->Instr
//    is memory latency + 1 cycle (registered queue output).
//  - Redirect (highest priority): pc <= redirect_pc; queue flushed; instr_valid=0 next cycle;
//    drop <= inflight + (arriving response ? -1 : 0) + (redirect-cycle handshake ? 1 : 0)
//    (imem_req_valid is low on a redirect cycle, so last term is 0). Pop in same cycle ignored.
//  - Simultaneous push+pop: count unchanged. Queue empty: Instr holds last value.
//  - Reset mid-operation: state cleared immediately; responses returning after reset
//    deasserts are NOT tracked -- memory must also be reset.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect_pc[1:0]!=0 -> state HALT, misalign_err=1 (sticky),
//    no requests, queue flushed; next aligned redirect clears error, returns to FETCH.
//  Undefined: redirect_pc[1:0] forced to 00, no HALT state, misalign_err port absent.
// STRUCTURE
//  rv32i_pkg: XLEN=32, ILEN=32, INSTR_NOP=32'h0000_0013, fetch FSM state encoding.
//  Sub-module ifq_fifo (DEPTH x 64b {pc,instr}, push/pop/flush, count, empty/full).
// TESTING
//  1 rst 1->0, imem_req_ready=1, 1-cycle memory -> addrs 0x0,0x4,0x8...; Instr in order.
//  2 instr_ready=0, memory returns -> exactly DEPTH=2 requests then imem_req_valid=0.
//  3 2 in flight, redirect to 0x100 -> both stale words dropped; first instr_pc=0x100.
//  4 Redirect same cycle as pop and response -> no stale word ever seen by decode.
//  5 PC 0xFFFF_FFFC -> next request addr 0x0000_0000.
//  6 FETCH_MISALIGN_EN, redirect 0x102 -> misalign_err=1, no reqs; redirect 0x200 -> clears.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, constants, the fetch FSM state encoding and
// the instruction-queue entry layout.
// Optional feature macro: FETCH_MISALIGN_EN adds the HALT state used when a
// redirect target is not word aligned.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
`ifdef FETCH_MISALIGN_EN
  localparam logic [1:0] ST_HALT  = 2'd2;
`endif

  // One instruction-queue entry: PC in the upper word, instruction below
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry queue of 64-bit {pc,instr} words between the fetch
// logic and decode. The head entry is held in a register so the consumer
// sees a registered output; while empty the head keeps its last value.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i/data_i  write one entry
//   pop_i          consume the head entry (ignored when empty)
//   flush_i        drop all entries (wins over push and pop)
//   count_o        number of stored entries
//   empty_o/full_o occupancy flags
//   head_o         registered head entry
module ifq_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [63:0]                  data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [63:0]                  head_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      head_q, head_d;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign do_pop_s = pop_i && (count_q != '0);
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign head_o   = head_q;

  // Next-state for storage, pointers, occupancy and the registered head
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop_s);
    end
    // Look at the post-update array so a push into an empty queue is visible
    // at the head on the very next cycle.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Queue state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 64'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Owns the PC, issues word requests
// to instruction memory, queues returned words tagged with their PC and hands
// them to decode over valid/ready. A redirect loads a new PC, flushes the
// queue and discards every response still in flight.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   redirect_valid/redirect_pc        taken branch/jump and its target
//   imem_req_valid/ready/addr         request channel to instruction memory
//   imem_rsp_valid/data               in-order read data, always accepted
//   instr_valid/ready, Instr/instr_pc instruction and its PC to decode
//   misalign_err                      sticky misaligned-target flag (macro only)
// Optional feature macro: FETCH_MISALIGN_EN. When defined, a misaligned
// redirect halts fetching and raises misalign_err until an aligned redirect;
// when undefined, the target's low two bits are simply cleared.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_s;
  logic             empty_s, full_s;
  logic             credit_ok_s, req_fire_s, rsp_take_s, keep_s;
  logic [XLEN-1:0]  target_s;
  ifq_entry_t       push_entry_s, head_entry_s;
`ifdef FETCH_MISALIGN_EN
  logic             misalign_s;
  logic             err_q, err_d;

  assign target_s     = redirect_pc;
  assign misalign_s   = (redirect_pc[1:0] != 2'b00);
  assign misalign_err = err_q;
`else
  assign target_s = {redirect_pc[31:2], 2'b00};
`endif

  // Queued plus in-flight words never exceed DEPTH, so a response always
  // finds room in the queue.
  assign credit_ok_s    = ({1'b0, count_s} + {1'b0, inflight_q}) < (CNT_W+1)'(DEPTH);
  assign imem_req_valid = (state_q == ST_FETCH) && credit_ok_s && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign rsp_take_s     = imem_rsp_valid && (inflight_q != '0);
  assign keep_s         = rsp_take_s && (drop_q == '0) && !redirect_valid;

  assign push_entry_s = '{pc: tag_q, instr: imem_rsp_data};
  assign instr_valid  = !empty_s;
  assign Instr        = head_entry_s.instr;
  assign instr_pc     = head_entry_s.pc;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep_s && !full_s),
    .data_i  (push_entry_s),
    .pop_i   (instr_ready),
    .flush_i (redirect_valid),
    .count_o (count_s),
    .empty_o (empty_s),
    .full_o  (full_s),
    .head_o  (head_entry_s)
  );

  // FSM, PC, PC-tag, in-flight and drop bookkeeping
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CNT_W'(req_fire_s) - CNT_W'(rsp_take_s);
`ifdef FETCH_MISALIGN_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_EN
      ST_HALT:  state_d = ST_HALT;
`endif
      default:  state_d = ST_IDLE;
    endcase
    if (redirect_valid) begin
      pc_d    = target_s;
      tag_d   = target_s;
      // Everything still outstanding is stale; a response arriving right now
      // is consumed (and discarded) this cycle, so it is not counted again.
      drop_d  = inflight_q - CNT_W'(rsp_take_s);
      state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_EN
      if (misalign_s) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end else begin
        err_d   = 1'b0;
      end
`endif
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_take_s) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          tag_d = tag_q + 32'd4;
        end
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Fetch control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Sticky misaligned-target flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic        misalign_err;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (Instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int req_pct, dec_pct, lat_min, lat_max;

  // Memory model: pending addresses with the cycle their data is due
  logic [31:0] pend_a[$];
  int          pend_due[$];
  int          last_due;

  // Reference model: after reset or a redirect to T, decode must see T, T+4,
  // T+8 ... each with the memory word stored at that address, and requests
  // must walk the same sequence.
  logic [31:0] exp_pc, req_pc, last_pop_pc;
  int          reqs_since, pops_since, n_req, n_pop, first_fire, first_valid;
  logic [31:0] req_log[$];
  bit          coinc_arm;
  int          coinc_hits;
  bit          halted;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  task automatic model_restart(input logic [31:0] t);
    exp_pc     = t;
    req_pc     = t;
    reqs_since = 0;
    pops_since = 0;
  endtask

  task automatic drive_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    instr_ready    = 1'b0;
    pend_a.delete();
    pend_due.delete();
    last_due    = cyc;
    halted      = 1'b0;
    first_fire  = -1;
    first_valid = -1;
    model_restart(RESET_PC);
  endtask

  // One clock cycle: drive memory/decode/redirect, then score what happens
  // at the coming rising edge against the reference model.
  task automatic tick(input logic redir, input logic [31:0] rpc);
    logic        r, fire, pop;
    logic [31:0] tgt;
    int          due;
    r = redir;
    @(negedge clk);
    if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_a.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    imem_req_ready = ($urandom_range(99) < req_pct);
    instr_ready    = ($urandom_range(99) < dec_pct);
    if (coinc_arm && imem_rsp_valid && instr_valid) begin
      r           = 1'b1;
      instr_ready = 1'b1;
      coinc_arm   = 1'b0;
      coinc_hits++;
    end
    redirect_valid = r;
    redirect_pc    = rpc;
    #1;
    fire = imem_req_valid && imem_req_ready;
    pop  = instr_valid && instr_ready && !r;
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (r) begin
      vec++;
      if (imem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL redir_req_gate: imem_req_valid=%b required 0 at cycle %0d", imem_req_valid, cyc);
      end
    end
`ifdef FETCH_MISALIGN_EN
    if (halted) begin
      vec++;
      if (imem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL halt_no_req: imem_req_valid=%b required 0 at cycle %0d", imem_req_valid, cyc);
      end
    end
`endif
    if (pop) begin
      vec++;
      if (instr_pc !== exp_pc || Instr !== word(exp_pc)) begin
        errs++;
        $display("FAIL instr_stream: pc=%h instr=%h required pc=%h instr=%h", instr_pc, Instr, exp_pc, word(exp_pc));
      end
      last_pop_pc = instr_pc;
      exp_pc      = exp_pc + 32'd4;
      pops_since++;
      n_pop++;
    end
    if (fire) begin
      vec++;
      if (imem_req_addr !== req_pc) begin
        errs++;
        $display("FAIL req_addr: addr=%h required %h", imem_req_addr, req_pc);
      end
      vec++;
      if (reqs_since - pops_since >= DEPTH) begin
        errs++;
        $display("FAIL credit: %0d words ahead of decode, required below %0d before a request", reqs_since - pops_since, DEPTH);
      end
      if (first_fire < 0) first_fire = cyc;
      req_log.push_back(imem_req_addr);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_a.push_back(imem_req_addr);
      pend_due.push_back(due);
      req_pc = req_pc + 32'd4;
      reqs_since++;
      n_req++;
    end
    if (r) begin
`ifdef FETCH_MISALIGN_EN
      halted = (rpc[1:0] != 2'b00);
      tgt    = rpc;
`else
      tgt    = {rpc[31:2], 2'b00};
`endif
      model_restart(tgt);
    end
    cyc++;
  endtask

  task automatic set_knobs(input int rq, input int dq, input int lmin, input int lmax);
    req_pct = rq;
    dec_pct = dq;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  task automatic test_reset();
    drive_reset();
    #1;
    vec++;
    if (instr_valid !== 1'b0 || Instr !== 32'd0 || instr_pc !== 32'd0 ||
        imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      errs++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%h req=%b addr=%h required all 0",
               instr_valid, Instr, instr_pc, imem_req_valid, imem_req_addr);
    end
`ifdef FETCH_MISALIGN_EN
    vec++;
    if (misalign_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_err: misalign_err=%b required 0", misalign_err);
    end
`endif
    repeat (2) @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    vec++;
    if (imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_req: imem_req_valid=%b required 0 in first cycle after reset", imem_req_valid);
    end
  endtask

  task automatic test_sequential();
    int p0;
    set_knobs(100, 100, 1, 1);
    req_log.delete();
    p0 = n_pop;
    repeat (20) tick(1'b0, 32'd0);
    vec++;
    if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
      errs++;
      $display("FAIL seq_addrs: %0d requests, first %h required 0,4,8", req_log.size(),
               (req_log.size() > 0) ? req_log[0] : 32'hx);
    end
    vec++;
    if (first_fire < 0 || first_valid - first_fire != 2) begin
      errs++;
      $display("FAIL first_latency: %0d cycles from request to Instr, required 2", first_valid - first_fire);
    end
    vec++;
    if (n_pop - p0 < 5) begin
      errs++;
      $display("FAIL seq_progress: %0d instructions in 20 cycles, required at least 5", n_pop - p0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    set_knobs(100, 0, 1, 1);
    tick(1'b1, 32'h0000_0040);
    r0 = n_req;
    repeat (10) tick(1'b0, 32'd0);
    vec++;
    if (n_req - r0 != DEPTH) begin
      errs++;
      $display("FAIL bp_req_count: %0d requests while decode stalled, required %0d", n_req - r0, DEPTH);
    end
    vec++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      errs++;
      $display("FAIL bp_state: req=%b valid=%b pc=%h required 0,1,00000040", imem_req_valid, instr_valid, instr_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    int k, p0;
    set_knobs(100, 0, 3, 3);
    tick(1'b1, 32'h0000_0080);
    k = 0;
    while (pend_a.size() < 2 && k < 10) begin
      tick(1'b0, 32'd0);
      k++;
    end
    vec++;
    if (pend_a.size() != 2) begin
      errs++;
      $display("FAIL two_inflight: %0d in flight, required 2", pend_a.size());
    end
    tick(1'b1, 32'h0000_0100);
    dec_pct = 100;
    p0 = n_pop;
    k  = 0;
    while (n_pop == p0 && k < 30) begin
      tick(1'b0, 32'd0);
      k++;
    end
    vec++;
    if (n_pop == p0 || last_pop_pc !== 32'h100) begin
      errs++;
      $display("FAIL drop_stale: first pc after redirect %h (pops %0d) required 00000100", last_pop_pc, n_pop - p0);
    end
  endtask

  task automatic test_redirect_pop_rsp();
    int k, p0, h0;
    set_knobs(100, 0, 1, 1);
    tick(1'b1, 32'h0000_0300);
    h0        = coinc_hits;
    coinc_arm = 1'b1;
    k = 0;
    while (coinc_hits == h0 && k < 20) begin
      tick(1'b0, 32'h0000_0400);
      k++;
    end
    coinc_arm = 1'b0;
    vec++;
    if (coinc_hits != h0 + 1) begin
      errs++;
      $display("FAIL coincidence: redirect with pop and response hit %0d times, required 1", coinc_hits - h0);
    end
    dec_pct = 100;
    p0 = n_pop;
    k  = 0;
    while (n_pop == p0 && k < 30) begin
      tick(1'b0, 32'd0);
      k++;
    end
    vec++;
    if (n_pop == p0 || last_pop_pc !== 32'h400) begin
      errs++;
      $display("FAIL coinc_first: first pc %h (pops %0d) required 00000400", last_pop_pc, n_pop - p0);
    end
  endtask

  task automatic test_wrap();
    set_knobs(100, 100, 1, 1);
    tick(1'b1, 32'hFFFF_FFFC);
    req_log.delete();
    repeat (10) tick(1'b0, 32'd0);
    vec++;
    if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
      errs++;
      $display("FAIL pc_wrap: %0d requests, second %h required FFFFFFFC then 00000000", req_log.size(),
               (req_log.size() > 1) ? req_log[1] : 32'hx);
    end
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    int r0, p0;
    set_knobs(100, 100, 2, 2);
    tick(1'b1, 32'h0000_0102);
    r0 = n_req;
    repeat (6) tick(1'b0, 32'd0);
    vec++;
    if (misalign_err !== 1'b1 || n_req != r0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL misalign_halt: err=%b reqs=%0d valid=%b required 1,0,0", misalign_err, n_req - r0, instr_valid);
    end
    tick(1'b1, 32'h0000_0200);
    p0 = n_pop;
    repeat (8) tick(1'b0, 32'd0);
    vec++;
    if (misalign_err !== 1'b0 || n_pop == p0) begin
      errs++;
      $display("FAIL misalign_clear: err=%b pops=%0d required 0 and some pops", misalign_err, n_pop - p0);
    end
  endtask
`endif

  task automatic test_random();
    int p0;
    logic [31:0] t;
    p0 = n_pop;
    for (int i = 0; i < 600; i++) begin
      set_knobs($urandom_range(90, 40), $urandom_range(90, 30), 1, 4);
      t = {$urandom_range(15), 8'h00, 12'($urandom())};
      if ($urandom_range(99) < 4) begin
        tick(1'b1, t);
      end else begin
        tick(1'b0, t);
      end
    end
    vec++;
    if (n_pop - p0 < 50) begin
      errs++;
      $display("FAIL random_progress: %0d instructions in 600 cycles, required at least 50", n_pop - p0);
    end
  endtask

  task automatic test_reset_mid();
    set_knobs(100, 0, 2, 2);
    tick(1'b1, 32'h0000_0500);
    repeat (3) tick(1'b0, 32'd0);
    drive_reset();
    #1;
    vec++;
    if (instr_valid !== 1'b0 || Instr !== 32'd0 || imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      errs++;
      $display("FAIL mid_reset: valid=%b instr=%h req=%b addr=%h required 0,0,0,%h",
               instr_valid, Instr, imem_req_valid, imem_req_addr, RESET_PC);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_knobs(100, 100, 1, 1);
    req_log.delete();
    repeat (8) tick(1'b0, 32'd0);
    vec++;
    if (req_log.size() < 1 || req_log[0] !== RESET_PC) begin
      errs++;
      $display("FAIL restart_addr: %0d requests after reset, first required %h", req_log.size(), RESET_PC);
    end
  endtask

  initial begin
    rst        = 1'b1;
    n_req      = 0;
    n_pop      = 0;
    coinc_arm  = 1'b0;
    coinc_hits = 0;
    set_knobs(0, 0, 1, 1);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop_rsp();
    test_wrap();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $fatal(1, "time limit");
  end

endmodule
